// File: rtl/tmds_vec_multi.sv
// tmds_vec_multi: multi-channel TMDS symbol validator and error corrector.
//
// Each lane's decoded byte is re-encoded into its three legal 10-bit forms.
// The result is compared against the received symbol. A bad video beat is
// replaced with the last good byte for that lane. After HOLD_MAX consecutive
// errors the lane is marked stale, and the raw byte is passed through instead.
// A saturating, clearable counter records every output beat with any error.
//
// Pipeline: stage 1 builds the candidate symbols, stage 2 compares them, and
// stage 3 drives the corrected outputs. Latency is fixed at 3 cycles. There
// is no back-pressure.
//
// Valid semantics: in_valid qualifies enc/dec/de in the cycle it is high.
// out_valid marks the cycles where ecdec/err/stale carry a new beat. While
// out_valid is low, those outputs hold their previous values.
//
// Optional build macro VEC_CTRL_CHECK_EN: when it is defined, blanking
// (de=0) symbols are checked against the four TMDS control tokens. When it is
// not defined, blanking beats are never flagged.
module tmds_vec_multi #(
   parameter int NCH      = 3,
   parameter int CNT_W    = 16,
   parameter int HOLD_MAX = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               de,
   input  logic [NCH*10-1:0]  enc,
   input  logic [NCH*8-1:0]   dec,
   input  logic               clr_cnt,
   output logic               out_valid,
   output logic [NCH*8-1:0]   ecdec,
   output logic [NCH-1:0]     err,
   output logic [NCH-1:0]     stale,
   output logic [CNT_W-1:0]   err_cnt
);

   localparam logic [7:0]       HOLD    = 8'(HOLD_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Returns the three legal encodings of a byte as {cand0, cand1, cand2}.
   function automatic logic [29:0] make_cands(input logic [7:0] d);
      logic [3:0] n1;
      logic       br;
      logic [7:0] qm;
      logic       q8;
      n1 = '0;
      for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d[i]};
      br = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      qm = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = br ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      q8 = ~br;
      return {{~q8, q8, (q8 ? qm : ~qm)}, {1'b1, q8, ~qm}, {1'b0, q8, qm}};
   endfunction

   // Stage 1 registers
   logic              v1_q, v1_d, de1_q, de1_d;
   logic [NCH*8-1:0]  dec1_q, dec1_d;
   logic [NCH*10-1:0] enc1_q, enc1_d;
   logic [NCH*30-1:0] cand1_q, cand1_d;

   // Stage 2 registers
   logic              v2_q, v2_d, de2_q, de2_d;
   logic [NCH*8-1:0]  dec2_q, dec2_d;
   logic [NCH-1:0]    ok2_q, ok2_d;

   // Stage 3 / output registers
   logic              out_valid_q, out_valid_d;
   logic [NCH*8-1:0]  ecdec_q, ecdec_d;
   logic [NCH*8-1:0]  last_good_q, last_good_d;
   logic [NCH-1:0]    err_q, err_d;
   logic [NCH-1:0]    stale_q, stale_d;
   logic [NCH*8-1:0]  run_q, run_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

   // Stage 1: capture inputs and build the candidate symbols for each lane.
   always_comb begin
      v1_d    = in_valid;
      de1_d   = de;
      dec1_d  = dec;
      enc1_d  = enc;
      cand1_d = '0;
      for (int c = 0; c < NCH; c++) cand1_d[c*30 +: 30] = make_cands(dec[c*8 +: 8]);
   end

   // Stage 2: decide per lane whether the received symbol is legal.
   always_comb begin
      v2_d   = v1_q;
      de2_d  = de1_q;
      dec2_d = dec1_q;
      ok2_d  = '0;
      for (int c = 0; c < NCH; c++) begin
         if (de1_q) begin
            ok2_d[c] = (enc1_q[c*10 +: 10] == cand1_q[c*30 + 20 +: 10]) ||
                       (enc1_q[c*10 +: 10] == cand1_q[c*30 + 10 +: 10]) ||
                       (enc1_q[c*10 +: 10] == cand1_q[c*30 +: 10]);
         end else begin
`ifdef VEC_CTRL_CHECK_EN
            ok2_d[c] = (enc1_q[c*10 +: 10] == 10'h354) || (enc1_q[c*10 +: 10] == 10'h0AB) ||
                       (enc1_q[c*10 +: 10] == 10'h154) || (enc1_q[c*10 +: 10] == 10'h2AB);
`else
            ok2_d[c] = 1'b1;
`endif
         end
      end
   end

   // Stage 3: substitute the last good byte, track error runs and stale lanes, and count errors.
   always_comb begin
      out_valid_d = v2_q;
      ecdec_d     = ecdec_q;
      last_good_d = last_good_q;
      err_d       = err_q;
      run_d       = run_q;
      stale_d     = stale_q;
      err_cnt_d   = err_cnt_q;
      if (v2_q) begin
         for (int c = 0; c < NCH; c++) begin
            if (de2_q) begin
               if (ok2_q[c]) begin
                  ecdec_d[c*8 +: 8]     = dec2_q[c*8 +: 8];
                  last_good_d[c*8 +: 8] = dec2_q[c*8 +: 8];
                  run_d[c*8 +: 8]       = 8'd0;
                  err_d[c]              = 1'b0;
               end else begin
                  err_d[c] = 1'b1;
                  if (run_q[c*8 +: 8] != HOLD) run_d[c*8 +: 8] = run_q[c*8 +: 8] + 8'd1;
                  // A stale lane forwards raw data rather than freezing the picture.
                  ecdec_d[c*8 +: 8] = (run_d[c*8 +: 8] == HOLD) ? dec2_q[c*8 +: 8]
                                                                 : last_good_q[c*8 +: 8];
               end
            end else begin
               ecdec_d[c*8 +: 8] = dec2_q[c*8 +: 8];
               err_d[c]          = ~ok2_q[c];
            end
            stale_d[c] = (run_d[c*8 +: 8] == HOLD);
         end
         if (|err_d && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
      end
      if (clr_cnt) err_cnt_d = '0;
   end

   // State registers for all three stages, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         de1_q       <= 1'b0;
         dec1_q      <= '0;
         enc1_q      <= '0;
         cand1_q     <= '0;
         v2_q        <= 1'b0;
         de2_q       <= 1'b0;
         dec2_q      <= '0;
         ok2_q       <= '0;
         out_valid_q <= 1'b0;
         ecdec_q     <= '0;
         last_good_q <= '0;
         err_q       <= '0;
         stale_q     <= '0;
         run_q       <= '0;
         err_cnt_q   <= '0;
      end else begin
         v1_q        <= v1_d;
         de1_q       <= de1_d;
         dec1_q      <= dec1_d;
         enc1_q      <= enc1_d;
         cand1_q     <= cand1_d;
         v2_q        <= v2_d;
         de2_q       <= de2_d;
         dec2_q      <= dec2_d;
         ok2_q       <= ok2_d;
         out_valid_q <= out_valid_d;
         ecdec_q     <= ecdec_d;
         last_good_q <= last_good_d;
         err_q       <= err_d;
         stale_q     <= stale_d;
         run_q       <= run_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign ecdec     = ecdec_q;
   assign err       = err_q;
   assign stale     = stale_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tmds_vec_multi.sv
// Directed bench for tmds_vec_multi with NCH=3, CNT_W=2 and HOLD_MAX=3.
// Lane 0 carries the vectors under test. Lanes 1 and 2 carry a fixed legal symbol.
module tb_tmds_vec_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        de;
   logic [29:0] enc;
   logic [23:0] dec;
   logic        clr_cnt;
   logic        out_valid;
   logic [23:0] ecdec;
   logic [2:0]  err;
   logic [2:0]  stale;
   logic [1:0]  err_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   logic [9:0] oth_enc = 10'h100;

   tmds_vec_multi #(.NCH(3), .CNT_W(2), .HOLD_MAX(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .de(de), .enc(enc), .dec(dec),
      .clr_cnt(clr_cnt), .out_valid(out_valid), .ecdec(ecdec), .err(err),
      .stale(stale), .err_cnt(err_cnt)
   );

   // Clock generation.
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic d, input logic [7:0] dc, input logic [9:0] ec);
      in_valid = v;
      de       = d;
      dec      = {16'h0000, dc};
      enc      = {oth_enc, oth_enc, ec};
   endtask

   task automatic do_reset();
      oth_enc = 10'h100;
      clr_cnt = 1'b0;
      set_in(1'b0, 1'b1, 8'h00, 10'h100);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", out_valid); else n_pass++;
      n_checks++; if (ecdec !== 24'h0) $display("FAIL rst_ecdec got %h exp 000000", ecdec); else n_pass++;
      n_checks++; if (err !== 3'b000 || stale !== 3'b000) $display("FAIL rst_flags got err %b stale %b exp 000 000", err, stale); else n_pass++;
      n_checks++; if (err_cnt !== 2'd0) $display("FAIL rst_cnt got %0d exp 0", err_cnt); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_good();
      logic [7:0] dv [0:3];
      logic [9:0] ev [0:3];
      dv = '{8'h00, 8'hFF, 8'hFF, 8'h5A};
      ev = '{10'h100, 10'h200, 10'h0FF, 10'h09C};
      do_reset();
      for (int s = 0; s < 7; s++) begin
         if (s < 4) set_in(1'b1, 1'b1, dv[s], ev[s]); else set_in(1'b0, 1'b1, 8'h00, 10'h100);
         step();
         if (s >= 2 && s < 6) begin
            n_checks++; if (out_valid !== 1'b1 || ecdec[7:0] !== dv[s-2] || err !== 3'b000)
               $display("FAIL good_beat%0d got v%0b ec %h err %b exp v1 ec %h err 000", s-2, out_valid, ecdec[7:0], err, dv[s-2]);
            else n_pass++;
         end
      end
      n_checks++; if (out_valid !== 1'b0) $display("FAIL good_tail got %0b exp 0", out_valid); else n_pass++;
      n_checks++; if (err_cnt !== 2'd0) $display("FAIL good_cnt got %0d exp 0", err_cnt); else n_pass++;
   endtask

   task automatic test_subst();
      do_reset();
      set_in(1'b1, 1'b1, 8'h00, 10'h100); step();
      set_in(1'b1, 1'b1, 8'h5A, 10'h000); step();
      set_in(1'b0, 1'b1, 8'h00, 10'h100); step();
      n_checks++; if (ecdec[7:0] !== 8'h00 || err !== 3'b000) $display("FAIL sub_first got ec %h err %b exp 00 000", ecdec[7:0], err); else n_pass++;
      step();
      n_checks++; if (out_valid !== 1'b1 || ecdec[7:0] !== 8'h00 || err !== 3'b001)
         $display("FAIL sub_second got v%0b ec %h err %b exp v1 00 001", out_valid, ecdec[7:0], err); else n_pass++;
      n_checks++; if (err_cnt !== 2'd1) $display("FAIL sub_cnt got %0d exp 1", err_cnt); else n_pass++;
   endtask

   task automatic test_stale();
      logic [7:0] dv [0:5];
      logic [9:0] ev [0:5];
      logic [7:0] exp_ec [0:5];
      logic       exp_er [0:5];
      logic       exp_st [0:5];
      dv     = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'hFF};
      ev     = '{10'h100, 10'h000, 10'h000, 10'h000, 10'h000, 10'h200};
      exp_ec = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h11, 8'hFF};
      exp_er = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_st = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int s = 0; s < 8; s++) begin
         if (s < 6) set_in(1'b1, 1'b1, dv[s], ev[s]); else set_in(1'b0, 1'b1, 8'h00, 10'h100);
         step();
         if (s >= 2) begin
            n_checks++; if (ecdec[7:0] !== exp_ec[s-2] || err[0] !== exp_er[s-2] || stale[0] !== exp_st[s-2])
               $display("FAIL stale_beat%0d got ec %h err %b stale %b exp ec %h err %b stale %b",
                        s-2, ecdec[7:0], err[0], stale[0], exp_ec[s-2], exp_er[s-2], exp_st[s-2]);
            else n_pass++;
         end
      end
      n_checks++; if (err_cnt !== 2'd3) $display("FAIL stale_cnt got %0d exp 3", err_cnt); else n_pass++;
   endtask

   task automatic test_bubble_sat();
      do_reset();
      set_in(1'b1, 1'b1, 8'h5A, 10'h000); step();
      set_in(1'b0, 1'b1, 8'h33, 10'h000); step();
      set_in(1'b1, 1'b1, 8'h11, 10'h000); step();
      n_checks++; if (out_valid !== 1'b1 || err !== 3'b001 || err_cnt !== 2'd1)
         $display("FAIL bub_first got v%0b err %b cnt %0d exp v1 001 1", out_valid, err, err_cnt); else n_pass++;
      set_in(1'b1, 1'b1, 8'h5A, 10'h000); step();
      n_checks++; if (out_valid !== 1'b0 || err !== 3'b001 || ecdec[7:0] !== 8'h00 || err_cnt !== 2'd1)
         $display("FAIL bub_hold got v%0b err %b ec %h cnt %0d exp v0 001 00 1", out_valid, err, ecdec[7:0], err_cnt); else n_pass++;
      set_in(1'b1, 1'b1, 8'h5A, 10'h000); step();
      n_checks++; if (out_valid !== 1'b1 || err !== 3'b001 || err_cnt !== 2'd2)
         $display("FAIL bub_second got v%0b err %b cnt %0d exp v1 001 2", out_valid, err, err_cnt); else n_pass++;
      set_in(1'b1, 1'b1, 8'h5A, 10'h000); step();
      set_in(1'b0, 1'b1, 8'h00, 10'h100);
      for (int s = 0; s < 3; s++) step();
      n_checks++; if (err_cnt !== 2'd3) $display("FAIL sat_cnt got %0d exp 3", err_cnt); else n_pass++;
      set_in(1'b1, 1'b1, 8'h5A, 10'h000); step();
      set_in(1'b0, 1'b1, 8'h00, 10'h100); step();
      clr_cnt = 1'b1; step();
      clr_cnt = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || err[0] !== 1'b1 || err_cnt !== 2'd0)
         $display("FAIL clr_cnt got v%0b err %b cnt %0d exp v1 1 0", out_valid, err[0], err_cnt); else n_pass++;
   endtask

   task automatic test_ctrl();
      logic       exp_e2;
      logic [1:0] exp_cnt;
`ifdef VEC_CTRL_CHECK_EN
      exp_e2 = 1'b1; exp_cnt = 2'd1;
`else
      exp_e2 = 1'b0; exp_cnt = 2'd0;
`endif
      do_reset();
      oth_enc = 10'h354;
      set_in(1'b1, 1'b0, 8'hA5, 10'h354); step();
      set_in(1'b1, 1'b0, 8'h3C, 10'h3FF); step();
      set_in(1'b0, 1'b0, 8'h00, 10'h354); step();
      n_checks++; if (out_valid !== 1'b1 || err !== 3'b000 || ecdec[7:0] !== 8'hA5)
         $display("FAIL ctrl_tok got v%0b err %b ec %h exp v1 000 a5", out_valid, err, ecdec[7:0]); else n_pass++;
      step();
      n_checks++; if (err[0] !== exp_e2 || ecdec[7:0] !== 8'h3C || stale !== 3'b000)
         $display("FAIL ctrl_bad got err %b ec %h stale %b exp err %b ec 3c stale 000", err[0], ecdec[7:0], stale, exp_e2); else n_pass++;
      n_checks++; if (err_cnt !== exp_cnt) $display("FAIL ctrl_cnt got %0d exp %0d", err_cnt, exp_cnt); else n_pass++;
      oth_enc = 10'h100;
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_in(1'b1, 1'b1, 8'hFF, 10'h200); step();
      set_in(1'b1, 1'b1, 8'h5A, 10'h000); step();
      set_in(1'b0, 1'b1, 8'h00, 10'h100); step(); step();
      n_checks++; if (ecdec[7:0] !== 8'hFF || err_cnt !== 2'd1) $display("FAIL mid_pre got ec %h cnt %0d exp ff 1", ecdec[7:0], err_cnt); else n_pass++;
      set_in(1'b1, 1'b1, 8'h00, 10'h100); step();
      set_in(1'b1, 1'b1, 8'h00, 10'h100); step();
      set_in(1'b0, 1'b1, 8'h00, 10'h100);
      rst = 1'b1; step();
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         step();
         n_checks++; if (out_valid !== 1'b0 || err_cnt !== 2'd0)
            $display("FAIL mid_flush%0d got v%0b cnt %0d exp v0 0", s, out_valid, err_cnt); else n_pass++;
      end
      set_in(1'b1, 1'b1, 8'h5A, 10'h000); step();
      set_in(1'b0, 1'b1, 8'h00, 10'h100); step(); step();
      n_checks++; if (out_valid !== 1'b1 || ecdec[7:0] !== 8'h00 || err[0] !== 1'b1)
         $display("FAIL mid_lastgood got v%0b ec %h err %b exp v1 00 1", out_valid, ecdec[7:0], err[0]); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_good();
      test_subst();
      test_stale();
      test_bubble_sat();
      test_ctrl();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
